id_ex_stage: RTL

//  Instruction-decode stage plus ID/EX pipeline register of the 5-stage MIPS pipe.

---
 rtl/id_ex_stage_pkg.sv | 36 +++
 rtl/id_ex_stage_ctrl_decode.sv | 58 +++++
 rtl/id_ex_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS decode definitions: opcodes, instruction field positions and
// the control bundle carried from ID into EX.
package id_ex_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned IMM_MSB   = 15;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic branch;
  } ctrl_t;

  typedef enum logic [1:0] {
    DST_NONE,
    DST_RT,
    DST_RD
  } dst_sel_e;

endpackage

// File: rtl/id_ex_stage_ctrl_decode.sv
// Combinational opcode decode: control bits, destination register and
// whether the instruction reads rt (for load-use hazard detection).
module id_ctrl_decode
  import id_ex_stage_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [4:0] i_rt,
  input  logic [4:0] i_rd,
  output ctrl_t      o_ctrl,
  output logic [4:0] o_dst,
  output logic       o_uses_rt
);

  dst_sel_e w_dst_sel;

  always_comb begin
    o_ctrl    = '0;
    w_dst_sel = DST_NONE;
    o_uses_rt = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_ctrl.reg_write = 1'b1;
        w_dst_sel        = DST_RD;
        o_uses_rt        = 1'b1;
      end
      OP_LW: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        w_dst_sel        = DST_RT;
      end
      OP_SW: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_uses_rt        = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl.branch = 1'b1;
        o_uses_rt     = 1'b1;
      end
      OP_ADDI: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        w_dst_sel        = DST_RT;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (w_dst_sel)
      DST_RT:  o_dst = i_rt;
      DST_RD:  o_dst = i_rd;
      default: o_dst = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID stage and ID/EX pipeline register: register-file addressing, writeback
// bypass, load-use stall, branch flush and a saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned bit_size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         IF_ID_instr,
  input  logic [bit_size-1:0] IF_ID_pc,
  input  logic                IF_ID_valid,
  input  logic                flush,
  output logic [4:0]          Read_addr_1,
  output logic [4:0]          Read_addr_2,
  input  logic [bit_size-1:0] Read_data_1,
  input  logic [bit_size-1:0] Read_data_2,
  input  logic                WB_RegWrite,
  input  logic [4:0]          WB_Write_addr,
  input  logic [bit_size-1:0] WB_Write_data,
  output logic                stall,
  output logic                ID_EX_valid,
  output logic [bit_size-1:0] ID_EX_pc,
  output logic [bit_size-1:0] ID_EX_rs_data,
  output logic [bit_size-1:0] ID_EX_rt_data,
  output logic [bit_size-1:0] ID_EX_imm,
  output logic [4:0]          ID_EX_rs,
  output logic [4:0]          ID_EX_rt,
  output logic [4:0]          ID_EX_dst,
  output logic [5:0]          ID_EX_funct,
  output logic                ID_EX_RegWrite,
  output logic                ID_EX_MemRead,
  output logic                ID_EX_MemWrite,
  output logic                ID_EX_ALUSrc,
  output logic                ID_EX_Branch,
  output logic [31:0]         bubble_count
);

  logic [4:0]          w_rs, w_rt, w_rd, w_dst;
  logic [5:0]          w_op;
  logic                w_uses_rt;
  ctrl_t               w_ctrl;
  logic [bit_size-1:0] w_rs_data, w_rt_data, w_imm;
  logic                w_hazard, w_bubble;

  logic                r_valid;
  logic [bit_size-1:0] r_pc, r_rs_data, r_rt_data, r_imm;
  logic [4:0]          r_rs, r_rt, r_dst;
  logic [5:0]          r_funct;
  ctrl_t               r_ctrl;
  logic [31:0]         r_bubble_count;

  assign w_op = IF_ID_instr[OP_MSB:OP_LSB];
  assign w_rs = IF_ID_instr[RS_MSB:RS_LSB];
  assign w_rt = IF_ID_instr[RT_MSB:RT_LSB];
  assign w_rd = IF_ID_instr[RD_MSB:RD_LSB];
  assign w_imm = {{(bit_size-16){IF_ID_instr[IMM_MSB]}}, IF_ID_instr[IMM_MSB:0]};

  assign Read_addr_1 = w_rs;
  assign Read_addr_2 = w_rt;

  id_ctrl_decode u_decode (
    .i_op      (w_op),
    .i_rt      (w_rt),
    .i_rd      (w_rd),
    .o_ctrl    (w_ctrl),
    .o_dst     (w_dst),
    .o_uses_rt (w_uses_rt)
  );

  // $0 is forced to zero regardless of regfile contents or a stray WB to $0.
  always_comb begin
    w_rs_data = Read_data_1;
    if (w_rs == '0)
      w_rs_data = '0;
    else if (WB_RegWrite && (WB_Write_addr == w_rs))
      w_rs_data = WB_Write_data;
  end

  always_comb begin
    w_rt_data = Read_data_2;
    if (w_rt == '0)
      w_rt_data = '0;
    else if (WB_RegWrite && (WB_Write_addr == w_rt))
      w_rt_data = WB_Write_data;
  end

  assign w_hazard = r_valid && r_ctrl.mem_read && (r_dst != '0) &&
                    ((r_dst == w_rs) || (w_uses_rt && (r_dst == w_rt)));
  assign stall    = IF_ID_valid && w_hazard && !flush;
  assign w_bubble = flush || stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid        <= 1'b0;
      r_pc           <= '0;
      r_rs_data      <= '0;
      r_rt_data      <= '0;
      r_imm          <= '0;
      r_rs           <= '0;
      r_rt           <= '0;
      r_dst          <= '0;
      r_funct        <= '0;
      r_ctrl         <= '0;
      r_bubble_count <= '0;
    end else if (w_bubble) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_dst     <= '0;
      r_funct   <= '0;
      r_ctrl    <= '0;
      if (r_bubble_count != '1)
        r_bubble_count <= r_bubble_count + 32'd1;
    end else begin
      r_valid   <= IF_ID_valid;
      r_pc      <= IF_ID_pc;
      r_rs_data <= w_rs_data;
      r_rt_data <= w_rt_data;
      r_imm     <= w_imm;
      r_rs      <= w_rs;
      r_rt      <= w_rt;
      r_dst     <= w_dst;
      r_funct   <= IF_ID_instr[FUNCT_MSB:0];
      r_ctrl    <= w_ctrl;
    end
  end

  assign ID_EX_valid    = r_valid;
  assign ID_EX_pc       = r_pc;
  assign ID_EX_rs_data  = r_rs_data;
  assign ID_EX_rt_data  = r_rt_data;
  assign ID_EX_imm      = r_imm;
  assign ID_EX_rs       = r_rs;
  assign ID_EX_rt       = r_rt;
  assign ID_EX_dst      = r_dst;
  assign ID_EX_funct    = r_funct;
  assign ID_EX_RegWrite = r_ctrl.reg_write;
  assign ID_EX_MemRead  = r_ctrl.mem_read;
  assign ID_EX_MemWrite = r_ctrl.mem_write;
  assign ID_EX_ALUSrc   = r_ctrl.alu_src;
  assign ID_EX_Branch   = r_ctrl.branch;
  assign bubble_count   = r_bubble_count;

endmodule
